// File: rtl/extrinsic_interleaver_if.sv
// extrinsic_interleaver_if: block-control, extrinsic-in and a-priori-out signals of the QPP interleaver.
// The deint signal is present only when EXTRINSIC_INTERLEAVER_DEINT_EN is defined.
interface extrinsic_interleaver_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       blklen;
  logic              valid_blklen;
  logic [DATA_W-1:0] extrinsic;
  logic              valid_extrinsic;
  logic              apriori_req;
  logic [DATA_W-1:0] apriori;
  logic              valid_apriori;
  logic              ready;
  logic              error;
`ifdef EXTRINSIC_INTERLEAVER_DEINT_EN
  logic              deint;
  modport master (output deint, output blklen, valid_blklen, extrinsic, valid_extrinsic, apriori_req,
                  input apriori, valid_apriori, ready, error);
  modport slave  (input deint, input blklen, valid_blklen, extrinsic, valid_extrinsic, apriori_req,
                  output apriori, valid_apriori, ready, error);
`else
  modport master (output blklen, valid_blklen, extrinsic, valid_extrinsic, apriori_req,
                  input apriori, valid_apriori, ready, error);
  modport slave  (input blklen, valid_blklen, extrinsic, valid_extrinsic, apriori_req,
                  output apriori, valid_apriori, ready, error);
`endif
endinterface

// File: rtl/extrinsic_interleaver.sv
// extrinsic_interleaver: buffers one LLR block, replays it in LTE QPP order (K = 512 or 6144).
// Defining EXTRINSIC_INTERLEAVER_DEINT_EN adds a per-block deint mode that scatters on write and reads linearly.
module extrinsic_interleaver #(
  parameter int DATA_W = 16,
  parameter int MAX_K  = 6144
) (
  input logic clk,
  input logic rst_n,
  extrinsic_interleaver_if.slave bus
);
  localparam int AW = $clog2(MAX_K);
  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [MAX_K];
  logic [DATA_W-1:0] r_apriori;
  logic r_valid, r_error;
  logic [AW-1:0] r_k, r_g0, r_f2x2, r_cnt, r_pi, r_g, w_pi_nx, w_g_nx, w_addr;
  logic [AW:0] w_pi_sum, w_g_sum;
  logic w_sup, w_big, w_accept, w_wr, w_rd, w_last, w_step, w_deint;
  assign w_big = bus.blklen == 16'd6144;
  assign w_sup = w_big || bus.blklen == 16'd512;
  assign w_last = r_cnt == r_k - 1'b1;
`ifdef EXTRINSIC_INTERLEAVER_DEINT_EN
  logic r_deint;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_deint <= 1'b0;
    else if (w_accept) r_deint <= bus.deint;
  assign w_deint = r_deint;
`else
  assign w_deint = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_accept = 1'b0;
    w_wr = 1'b0;
    w_rd = 1'b0;
    if (r_state == IDLE) begin
      w_accept = bus.valid_blklen && w_sup;
      w_next = w_accept ? CAPTURE : IDLE;
    end else if (r_state == CAPTURE) begin
      w_wr = bus.valid_extrinsic;
      w_next = (w_wr && w_last) ? READOUT : CAPTURE;
    end else begin
      w_rd = bus.apriori_req;
      w_next = (w_rd && w_last) ? IDLE : READOUT;
    end
  end
  // The permuted side (read when interleaving, write when de-interleaving) walks Pi; the other side is linear.
  assign w_step = w_deint ? w_wr : w_rd;
  assign w_addr = (w_wr == w_deint) ? r_pi : r_cnt;
  assign w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
  assign w_g_sum = {1'b0, r_g} + {1'b0, r_f2x2};
  assign w_pi_nx = (w_pi_sum >= {1'b0, r_k}) ? AW'(w_pi_sum - {1'b0, r_k}) : AW'(w_pi_sum);
  assign w_g_nx = (w_g_sum >= {1'b0, r_k}) ? AW'(w_g_sum - {1'b0, r_k}) : AW'(w_g_sum);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_k <= '0;
      r_g0 <= '0;
      r_f2x2 <= '0;
      r_cnt <= '0;
      r_pi <= '0;
      r_g <= '0;
    end else if (w_accept) begin
      r_k <= w_big ? AW'(6144) : AW'(512);
      r_g0 <= w_big ? AW'(743) : AW'(95);
      r_f2x2 <= w_big ? AW'(960) : AW'(128);
      r_g <= w_big ? AW'(743) : AW'(95);
      r_pi <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr || w_rd) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_wr && w_last) begin
        r_pi <= '0;
        r_g <= r_g0;
      end else if (w_step) begin
        r_pi <= w_pi_nx;
        r_g <= w_g_nx;
      end
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[w_addr] <= bus.extrinsic;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_apriori <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= w_rd;
      r_error <= r_state == IDLE && bus.valid_blklen && !w_sup;
      if (w_rd) r_apriori <= r_mem[w_addr];
    end
  assign bus.apriori = r_apriori;
  assign bus.valid_apriori = r_valid;
  assign bus.ready = r_state == IDLE;
  assign bus.error = r_error;
endmodule

// File: tb/tb_extrinsic_interleaver.sv
// tb_extrinsic_interleaver: table-driven and randomized checks against a closed-form QPP model
// (Pi(j) = (f1*j + f2*j*j) mod K) with a behavioural memory image.
module tb_extrinsic_interleaver;
  localparam int DATA_W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic deint_mode = 1'b0;
  logic [DATA_W-1:0] model_mem [6144];
  logic [DATA_W-1:0] data_buf [6144];
  logic [DATA_W-1:0] out_buf [6144];
  typedef struct {
    int   blklen;
    logic exp_error;
    logic exp_ready;
  } blk_vec_t;
  blk_vec_t blk_vecs [6];
  int first512 [4];
  int first6144 [3];
  int pulses;

  extrinsic_interleaver_if #(.DATA_W(DATA_W)) bus ();
  extrinsic_interleaver #(.DATA_W(DATA_W), .MAX_K(6144)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic int qpp(input int j, input int k);
    longint f1 = (k == 512) ? 31 : 263;
    longint f2 = (k == 512) ? 64 : 480;
    longint jj = j;
    return int'((f1 * jj + f2 * jj * jj) % k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int k, input logic d);
    bus.blklen = 16'(k);
    bus.valid_blklen = 1'b1;
`ifdef EXTRINSIC_INTERLEAVER_DEINT_EN
    bus.deint = d;
`endif
    deint_mode = d;
    step();
    bus.valid_blklen = 1'b0;
    check("start_ready_low", 32'(bus.ready), 0);
  endtask

  task automatic load(input int k, input bit gap, input bit poke);
    for (int i = 0; i < k; i++) begin
      bus.extrinsic = data_buf[i];
      bus.valid_extrinsic = 1'b1;
      bus.apriori_req = poke;
      bus.valid_blklen = poke;
      bus.blklen = 16'd1000;
      model_mem[deint_mode ? qpp(i, k) : i] = data_buf[i];
      step();
      check("capture_quiet", {29'd0, bus.ready, bus.valid_apriori, bus.error}, 0);
      if (gap && i < k - 1) begin
        bus.valid_extrinsic = 1'b0;
        bus.extrinsic = 16'($urandom);
        bus.apriori_req = 1'b0;
        step();
        check("capture_gap_quiet", {29'd0, bus.ready, bus.valid_apriori, bus.error}, 0);
      end
    end
    bus.valid_extrinsic = 1'b0;
    bus.apriori_req = 1'b0;
    bus.valid_blklen = 1'b0;
  endtask

  task automatic readout(input int k, input bit rnd, input int cycles, input int stop_after, output int n_pulse);
    int issued = 0;
    logic acc;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] last;
    last = out_buf[0];
    n_pulse = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.apriori_req = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.valid_extrinsic = 1'($urandom_range(0, 1));
      bus.extrinsic = 16'($urandom);
      acc = bus.apriori_req && issued < k;
      exp = acc ? model_mem[deint_mode ? issued : qpp(issued, k)] : last;
      step();
      check("readout_valid", 32'(bus.valid_apriori), 32'(acc));
      if (c > 0 || acc) check("readout_word", 32'(bus.apriori), 32'(exp));
      if (bus.valid_apriori) n_pulse++;
      if (acc) begin
        out_buf[issued] = bus.apriori;
        issued++;
        if (issued == k) check("ready_with_last_word", 32'(bus.ready), 1);
      end
      last = exp;
      if (issued == stop_after && issued < k) break;
    end
    bus.apriori_req = 1'b0;
    bus.valid_extrinsic = 1'b0;
  endtask

  initial begin
    blk_vecs[0] = '{1000, 1'b1, 1'b1};
    blk_vecs[1] = '{0, 1'b1, 1'b1};
    blk_vecs[2] = '{511, 1'b1, 1'b1};
    blk_vecs[3] = '{6145, 1'b1, 1'b1};
    blk_vecs[4] = '{512, 1'b0, 1'b0};
    blk_vecs[5] = '{6144, 1'b0, 1'b0};
    first512 = '{0, 95, 318, 157};
    first6144 = '{0, 743, 2446};
    bus.blklen = '0;
    bus.valid_blklen = 1'b0;
    bus.extrinsic = '0;
    bus.valid_extrinsic = 1'b0;
    bus.apriori_req = 1'b0;
`ifdef EXTRINSIC_INTERLEAVER_DEINT_EN
    bus.deint = 1'b0;
`endif
    step();
    step();
    check("reset_ready", 32'(bus.ready), 1);
    check("reset_valid", 32'(bus.valid_apriori), 0);
    check("reset_apriori", 32'(bus.apriori), 0);
    check("reset_error", 32'(bus.error), 0);
    rst_n = 1'b1;
    step();

    foreach (blk_vecs[v]) begin
      bus.blklen = 16'(blk_vecs[v].blklen);
      bus.valid_blklen = 1'b1;
      step();
      bus.valid_blklen = 1'b0;
      check("blklen_error", 32'(bus.error), 32'(blk_vecs[v].exp_error));
      check("blklen_ready", 32'(bus.ready), 32'(blk_vecs[v].exp_ready));
      check("blklen_no_output", 32'(bus.valid_apriori), 0);
      step();
      check("error_one_cycle", 32'(bus.error), 0);
      if (!blk_vecs[v].exp_ready) begin
        rst_n = 1'b0;
        #1;
        check("reset_in_capture_ready", 32'(bus.ready), 1);
        step();
        rst_n = 1'b1;
        step();
      end
    end

    for (int i = 0; i < 512; i++) data_buf[i] = 16'(i);
    start_block(512, 1'b0);
    load(512, 1'b0, 1'b0);
    readout(512, 1'b0, 514, 512, pulses);
    check("k512_pulses", 32'(pulses), 512);
    foreach (first512[i]) check("k512_first_words", 32'(out_buf[i]), 32'(first512[i]));
    check("k512_ready_after", 32'(bus.ready), 1);

    for (int i = 0; i < 6144; i++) data_buf[i] = 16'(i);
    start_block(6144, 1'b0);
    load(6144, 1'b1, 1'b0);
    readout(6144, 1'b0, 6144, 6144, pulses);
    check("k6144_pulses", 32'(pulses), 6144);
    foreach (first6144[i]) check("k6144_first_words", 32'(out_buf[i]), 32'(first6144[i]));

    for (int i = 0; i < 512; i++) data_buf[i] = 16'($urandom);
    start_block(512, 1'b0);
    load(512, 1'b0, 1'b0);
    readout(512, 1'b1, 2000, 100, pulses);
    check("abort_pulses", 32'(pulses), 100);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.valid_apriori), 0);
    check("abort_ready", 32'(bus.ready), 1);
    check("abort_apriori", 32'(bus.apriori), 0);
    step();
    rst_n = 1'b1;
    bus.apriori_req = 1'b1;
    step();
    bus.apriori_req = 1'b0;
    check("idle_req_ignored", 32'(bus.valid_apriori), 0);
    for (int i = 0; i < 512; i++) data_buf[i] = 16'($urandom);
    start_block(512, 1'b0);
    load(512, 1'b1, 1'b0);
    out_buf[0] = bus.apriori;
    readout(512, 1'b1, 3000, 512, pulses);
    check("random_pulses", 32'(pulses), 512);

    for (int i = 0; i < 512; i++) data_buf[i] = 16'($urandom);
    start_block(512, 1'b0);
    load(512, 1'b0, 1'b1);
    out_buf[0] = bus.apriori;
    readout(512, 1'b0, 520, 512, pulses);
    check("held_req_pulses", 32'(pulses), 512);

`ifdef EXTRINSIC_INTERLEAVER_DEINT_EN
    for (int i = 0; i < 512; i++) data_buf[i] = 16'(i);
    start_block(512, 1'b0);
    load(512, 1'b0, 1'b0);
    readout(512, 1'b0, 512, 512, pulses);
    for (int i = 0; i < 512; i++) data_buf[i] = out_buf[i];
    start_block(512, 1'b1);
    load(512, 1'b0, 1'b0);
    readout(512, 1'b0, 512, 512, pulses);
    check("deint_pulses", 32'(pulses), 512);
    check("deint_word1", 32'(out_buf[1]), 1);
    check("deint_word511", 32'(out_buf[511]), 511);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
